bnn_ctrl_param: RTL and testbench

//   Parametrised top-level sequencer for the BNN accelerator; next generation of the fixed 2-channel controller.

---
 rtl/bnn_ctrl_param.sv | 181 ++++++++++++++++++
 tb/tb_bnn_ctrl_param.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_ctrl_param.sv
// bnn_ctrl_param: parametrised BNN sequencer driving CH binary conv engines through
// CONV1/CONV2, capturing FC scores and reporting a signed argmax.
module bnn_ctrl_param #(
  parameter  int CH        = 2,
  parameter  int FMAP_BITS = 676,
  parameter  int W_PER_CH  = 9,
  parameter  int PIX_W     = 8,
  parameter  int PIX_THR   = 127,
  parameter  int NCLS      = 10,
  parameter  int FC_W      = 10,
  localparam int SW        = $clog2(CH+1) + 1,
  localparam int CIW       = $clog2(NCLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PIX_W-1:0]     pic_din,
  input  logic [CH-1:0]        conv_result,
  input  logic [CH-1:0]        conv_result_valid,
  input  logic [CH-1:0]        conv_done,
  output logic [CH-1:0]        conv_din,
  output logic [CH-1:0]        conv_start,
  output logic [CH-1:0]        weight_en,
  output logic                 stage,
  output logic [SW-1:0]        conv2_sum,
  output logic                 maxpool_valid,
  input  logic [NCLS*FC_W-1:0] fc_result,
  input  logic                 fc_result_valid,
  output logic [CIW-1:0]       class_idx,
  output logic [FC_W-1:0]      class_max,
  output logic                 done,
  output logic                 fmap_ovf
);

  // state    | meaning
  // S_IDLE   | waiting for start
  // S_CONV1  | thresholded pixels streamed, engine results written to fmaps
  // S_CONV2  | stored fmaps replayed, waiting for FC scores
  // S_ARGMAX | one class compared per cycle
  // S_FIN    | done pulse, result registers freshly loaded
  typedef enum logic [2:0] {S_IDLE, S_CONV1, S_CONV2, S_ARGMAX, S_FIN} state_t;

  localparam int WN  = CH * W_PER_CH;
  localparam int WCW = $clog2(WN + 1);
  localparam int PW  = $clog2(FMAP_BITS + 1);

  state_t                 state_q;
  logic [WCW-1:0]         wcnt_q;
  logic [PW-1:0]          wptr_q [CH];
  logic [PW-1:0]          rptr_q [CH];
  logic [FMAP_BITS-1:0]   fmap_q [CH];
  logic signed [FC_W-1:0] score_q [NCLS];
  logic [CIW-1:0]         acnt_q, idx_q, idx_d, class_idx_q;
  logic signed [FC_W-1:0] max_q, max_d, class_max_q;
  logic [CH-1:0]          weight_en_q, weight_en_d;
  logic signed [SW-1:0]   conv2_sum_q, sum_d;
  logic                   maxpool_valid_q, done_q, fmap_ovf_q;
  logic                   in_conv, pix_bit;

  always_comb begin
    in_conv    = (state_q == S_CONV1) || (state_q == S_CONV2);
    pix_bit    = (pic_din > PIX_W'(PIX_THR));
    conv_start = in_conv ? ~conv_done : '0;
    conv_din   = '0;
    for (int i = 0; i < CH; i++) begin
      if (state_q == S_CONV1)      conv_din[i] = pix_bit;
      else if (state_q == S_CONV2) conv_din[i] = fmap_q[i][rptr_q[i]];
    end
    sum_d = '0;
    for (int i = 0; i < CH; i++)
      sum_d = conv_result[i] ? sum_d + SW'(1) : sum_d - SW'(1);
    for (int k = 0; k < CH; k++)
      weight_en_d[k] = (|conv_start) && (int'(wcnt_q) >= k * W_PER_CH)
                       && (int'(wcnt_q) < (k + 1) * W_PER_CH);
    // First class seeds the running max unconditionally; later ones need a strict win.
    idx_d = idx_q;
    max_d = max_q;
    if (acnt_q == '0) begin
      idx_d = '0;
      max_d = score_q[0];
    end else if (score_q[acnt_q] > max_q) begin
      idx_d = acnt_q;
      max_d = score_q[acnt_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      wcnt_q          <= '0;
      acnt_q          <= '0;
      idx_q           <= '0;
      max_q           <= '0;
      class_idx_q     <= '0;
      class_max_q     <= '0;
      weight_en_q     <= '0;
      conv2_sum_q     <= '0;
      maxpool_valid_q <= 1'b0;
      done_q          <= 1'b0;
      fmap_ovf_q      <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        fmap_q[i] <= '0;
      end
      for (int k = 0; k < NCLS; k++) score_q[k] <= '0;
    end else begin
      weight_en_q     <= weight_en_d;
      conv2_sum_q     <= sum_d;
      maxpool_valid_q <= (state_q == S_CONV2) && (&conv_result_valid);
      done_q          <= 1'b0;
      if ((|conv_start) && (wcnt_q < WCW'(WN))) wcnt_q <= wcnt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_CONV1;
            fmap_ovf_q <= 1'b0;
            wcnt_q     <= '0;
            for (int i = 0; i < CH; i++) begin
              wptr_q[i] <= '0;
              rptr_q[i] <= '0;
            end
          end
        end
        S_CONV1: begin
          for (int i = 0; i < CH; i++) begin
            if (conv_result_valid[i]) begin
              if (wptr_q[i] < PW'(FMAP_BITS)) begin
                fmap_q[i][wptr_q[i]] <= conv_result[i];
                wptr_q[i]            <= wptr_q[i] + 1'b1;
              end else begin
                fmap_ovf_q <= 1'b1;
              end
            end
          end
          if (&conv_done) begin
            state_q <= S_CONV2;
            wcnt_q  <= '0;
            for (int i = 0; i < CH; i++) begin
              wptr_q[i] <= '0;
              rptr_q[i] <= '0;
            end
          end
        end
        S_CONV2: begin
          for (int i = 0; i < CH; i++)
            if (conv_start[i] && (rptr_q[i] < PW'(FMAP_BITS - 1)))
              rptr_q[i] <= rptr_q[i] + 1'b1;
          if (fc_result_valid) begin
            for (int k = 0; k < NCLS; k++) score_q[k] <= fc_result[k*FC_W +: FC_W];
            acnt_q  <= '0;
            state_q <= S_ARGMAX;
          end
        end
        S_ARGMAX: begin
          idx_q  <= idx_d;
          max_q  <= max_d;
          acnt_q <= acnt_q + 1'b1;
          if (acnt_q == CIW'(NCLS - 1)) begin
            state_q     <= S_FIN;
            done_q      <= 1'b1;
            class_idx_q <= idx_d;
            class_max_q <= max_d;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign weight_en     = weight_en_q;
  assign stage         = (state_q != S_CONV1);
  assign conv2_sum     = conv2_sum_q;
  assign maxpool_valid = maxpool_valid_q;
  assign class_idx     = class_idx_q;
  assign class_max     = class_max_q;
  assign done          = done_q;
  assign fmap_ovf      = fmap_ovf_q;

endmodule

// File: tb/tb_bnn_ctrl_param.sv
// tb_bnn_ctrl_param: randomized bench for bnn_ctrl_param; a bit-array fmap scoreboard
// and a plain argmax over the score list supply every expected value.
`timescale 1ns/1ps
module tb_bnn_ctrl_param;
  localparam int CH = 2, FMAP_BITS = 676, W_PER_CH = 9, PIX_W = 8, PIX_THR = 127;
  localparam int NCLS = 10, FC_W = 10;
  localparam int SW  = $clog2(CH+1) + 1;
  localparam int CIW = $clog2(NCLS);

  logic                 clk = 1'b0;
  logic                 rst, start, stage, maxpool_valid, fc_result_valid, done, fmap_ovf;
  logic [PIX_W-1:0]     pic_din;
  logic [CH-1:0]        conv_result, conv_result_valid, conv_done, conv_din, conv_start, weight_en;
  logic [SW-1:0]        conv2_sum;
  logic [NCLS*FC_W-1:0] fc_result;
  logic [CIW-1:0]       class_idx;
  logic [FC_W-1:0]      class_max;

  int errors = 0, checks = 0;
  bit mfmap [CH][FMAP_BITS];
  int mwptr [CH];
  bit movf;
  int exp_sum;
  bit exp_mpv;
  int scores [NCLS];

  always #5 clk = ~clk;

  bnn_ctrl_param dut (
    .clk(clk), .rst(rst), .start(start), .pic_din(pic_din),
    .conv_result(conv_result), .conv_result_valid(conv_result_valid), .conv_done(conv_done),
    .conv_din(conv_din), .conv_start(conv_start), .weight_en(weight_en), .stage(stage),
    .conv2_sum(conv2_sum), .maxpool_valid(maxpool_valid), .fc_result(fc_result),
    .fc_result_valid(fc_result_valid), .class_idx(class_idx), .class_max(class_max),
    .done(done), .fmap_ovf(fmap_ovf)
  );

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [CH-1:0] exp_wen(input int c);
    logic [CH-1:0] r;
    for (int k = 0; k < CH; k++) r[k] = (c >= k*W_PER_CH + 1) && (c <= (k+1)*W_PER_CH);
    return r;
  endfunction

  function automatic int pm_sum(input logic [CH-1:0] r);
    int s = 0;
    for (int i = 0; i < CH; i++) s += r[i] ? 1 : -1;
    return s;
  endfunction

  task automatic drive_zero();
    start = 0; pic_din = '0; conv_result = '0; conv_result_valid = '0; conv_done = '0;
    fc_result = '0; fc_result_valid = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      mwptr[i] = 0;
      for (int b = 0; b < FMAP_BITS; b++) mfmap[i][b] = 0;
    end
    movf = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_idx"}, class_idx, 0);
    chk({tag, "_max"}, class_max, 0);
    chk({tag, "_ovf"}, fmap_ovf, 0);
    chk({tag, "_stage"}, stage, 1);
    chk({tag, "_cstart"}, conv_start, 0);
    chk({tag, "_wen"}, weight_en, 0);
    chk({tag, "_din"}, conv_din, 0);
    chk({tag, "_sum"}, conv2_sum, 0);
    chk({tag, "_mpv"}, maxpool_valid, 0);
  endtask

  task automatic do_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int i = 0; i < CH; i++) mwptr[i] = 0;
    movf = 0;
  endtask

  // mode 0: ch0 gets 1010.., ch1 all ones; mode 1: random bits
  task automatic run_conv1(input int mode, input int tgt0, input int tgt1);
    int cnt [CH];
    int tgt [CH];
    int c;
    bit fin;
    logic [CH-1:0] e;
    tgt[0] = tgt0; tgt[1] = tgt1; cnt[0] = 0; cnt[1] = 0; c = 0; fin = 0;
    while (!fin && c < 5000) begin
      pic_din = (c == 0) ? 8'd127 : (c == 1) ? 8'd128 : PIX_W'($urandom);
      start = $urandom_range(0, 1);
      fc_result_valid = ($urandom_range(0, 7) == 0);
      fc_result = {$urandom, $urandom, $urandom, $urandom};
      conv_result = CH'($urandom);
      conv_result_valid = '0;
      fin = 1;
      for (int i = 0; i < CH; i++) begin
        if (cnt[i] < tgt[i] && $urandom_range(0, 1) == 1) begin
          conv_result_valid[i] = 1;
          if (cnt[i] >= FMAP_BITS)  conv_result[i] = ~mfmap[i][FMAP_BITS-1];
          else if (mode == 0)      conv_result[i] = (i == 0) ? (cnt[i] % 2 == 0) : 1'b1;
          else                     conv_result[i] = $urandom_range(0, 1);
          cnt[i]++;
        end
        conv_done[i] = (cnt[i] >= tgt[i]);
        if (cnt[i] < tgt[i]) fin = 0;
      end
      #1;
      e = {CH{pic_din > PIX_THR}};
      chk("c1_din", conv_din, e);
      e = ~conv_done;
      chk("c1_start", conv_start, e);
      chk("c1_stage", stage, 0);
      chk("c1_ovf", fmap_ovf, movf);
      if (c < 22) chk("c1_wen", weight_en, exp_wen(c));
      for (int i = 0; i < CH; i++)
        if (conv_result_valid[i]) begin
          if (mwptr[i] < FMAP_BITS) begin
            mfmap[i][mwptr[i]] = conv_result[i];
            mwptr[i]++;
          end else movf = 1;
        end
      exp_sum = pm_sum(conv_result);
      exp_mpv = 0;
      @(negedge clk);
      c++;
    end
    if (!fin) chk("c1_timeout", 0, 1);
  endtask

  task automatic run_conv2(input int ncyc, input int abort_at);
    logic [CH-1:0] e;
    int rb;
    for (int c = 0; c < ncyc; c++) begin
      pic_din = PIX_W'($urandom); start = $urandom_range(0, 1); conv_done = '0;
      fc_result_valid = 0; conv_result = CH'($urandom); conv_result_valid = CH'($urandom);
      #1;
      if (c == abort_at) begin
        rst = 1;
        #1;
        check_reset_outputs("abort");
        model_reset();
        return;
      end
      rb = (c < FMAP_BITS - 1) ? c : FMAP_BITS - 1;
      for (int i = 0; i < CH; i++) e[i] = mfmap[i][rb];
      chk("c2_din", conv_din, e);
      e = '1;
      chk("c2_start", conv_start, e);
      chk("c2_stage", stage, 1);
      chk("c2_sum", $signed(conv2_sum), exp_sum);
      chk("c2_mpv", maxpool_valid, exp_mpv);
      chk("c2_ovf", fmap_ovf, movf);
      if (c < 22) chk("c2_wen", weight_en, exp_wen(c));
      exp_sum = pm_sum(conv_result);
      exp_mpv = &conv_result_valid;
      @(negedge clk);
    end
  endtask

  task automatic run_fc(input string tag);
    int best, n;
    for (int k = 0; k < NCLS; k++) fc_result[k*FC_W +: FC_W] = FC_W'(scores[k]);
    best = 0;
    for (int k = 1; k < NCLS; k++) if (scores[k] > scores[best]) best = k;
    fc_result_valid = 1; conv_result_valid = '0; start = 0;
    @(posedge clk); #1;
    fc_result_valid = 0;
    fc_result = {$urandom, $urandom, $urandom, $urandom};
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, NCLS + 1);
    chk({tag, "_idx"}, class_idx, best);
    chk({tag, "_max"}, $signed(class_max), scores[best]);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, done, 0);
    chk({tag, "_idle_start"}, conv_start, 0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_hold_idx"}, class_idx, best);
    chk({tag, "_hold_max"}, $signed(class_max), scores[best]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_zero();
    rst = 1;
    model_reset();
    exp_sum = 0; exp_mpv = 0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 0;

    // Run A: patterned fmaps, full replay including pointer saturation
    do_start();
    run_conv1(0, FMAP_BITS, FMAP_BITS);
    run_conv2(FMAP_BITS + 4, -1);
    scores[0] = -5; scores[1] = -3; scores[2] = -3;
    for (int k = 3; k < NCLS; k++) scores[k] = -9;
    run_fc("A");

    // Run B: random fmaps and wide-range scores
    do_start();
    run_conv1(1, FMAP_BITS, FMAP_BITS);
    run_conv2($urandom_range(50, 100), -1);
    for (int k = 0; k < NCLS; k++) scores[k] = int'($urandom_range(0, 1023)) - 512;
    run_fc("B");

    // Run C: short partial writes, all-zero scores
    do_start();
    run_conv1(1, $urandom_range(60, 120), $urandom_range(60, 120));
    run_conv2(150, -1);
    for (int k = 0; k < NCLS; k++) scores[k] = 0;
    run_fc("C");

    // Run D: one extra strobe on ch0 overflows; bit 675 must survive
    do_start();
    run_conv1(1, FMAP_BITS + 1, FMAP_BITS);
    chk("ovf_set", fmap_ovf, 1);
    run_conv2(FMAP_BITS + 2, -1);
    for (int k = 0; k < NCLS; k++) scores[k] = -100;
    scores[7] = 200;
    run_fc("D");

    // Run E: next start clears the flag, then reset lands mid-CONV2
    do_start();
    #1;
    chk("ovf_clear", fmap_ovf, 0);
    run_conv1(1, $urandom_range(60, 120), $urandom_range(60, 120));
    run_conv2(300, $urandom_range(20, 200));
    repeat (2) @(negedge clk);
    rst = 0;
    drive_zero();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); #1;
      chk("post_rst_done", done, 0);
      chk("post_rst_stage", stage, 1);
    end
    chk("post_rst_idx", class_idx, 0);

    // Run F: re-run after reset, narrow score range so ties occur
    do_start();
    run_conv1(1, $urandom_range(60, 120), $urandom_range(60, 120));
    run_conv2(200, -1);
    for (int k = 0; k < NCLS; k++) scores[k] = int'($urandom_range(0, 7)) - 4;
    run_fc("F");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
